rx_frame_sampler: RTL

RX_FRAME_SAMPLER -- requirements
Module: rx_frame_sampler

---
 rtl/uart_rx_pkg.sv | 24 ++
 rtl/rx_sync.sv | 34 +++
 rtl/rx_frame_sampler.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: frame FSM states,
// parity_type encodings, oversampling default and the 3-sample vote.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } state_t;

  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  // The tick counter is 4 bits wide, so OVERSAMPLE must not exceed 16.
  localparam int OVERSAMPLE_DEF = 16;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line, plus a
// falling-edge detector on the synchronized level.
module rx_sync (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_rx,
  output logic o_line,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; blocking here would
  // collapse the two-flop chain into a single stage.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      // Reset to the idle (high) level so leaving reset cannot fake a start edge.
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_rx;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_line = r_sync;
  assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/rx_frame_sampler.sv
// UART frame sampler: oversampled start/data/parity/stop capture with
// 3-sample majority voting; frame fields are published in one DONE clock.
module rx_frame_sampler
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       data_rx,
  input  logic       baud_tick,
  input  logic [1:0] parity_type,
  output logic [7:0] raw_data,
  output logic       parity_bit,
  output logic       start_bit,
  output logic       stop_bit,
  output logic       frame_valid,
  output logic       active
);

  localparam logic [3:0] C_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] C_S0   = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] C_S1   = 4'(OVERSAMPLE / 2);
  localparam logic [3:0] C_S2   = 4'(OVERSAMPLE / 2 + 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [2:0] r_bit_idx;
  logic [1:0] r_ptype;
  logic       r_s0;
  logic       r_s1;

  logic [7:0] r_sh_data;
  logic       r_sh_parity;
  logic       r_sh_start;
  logic       r_sh_stop;

  logic [7:0] r_raw_data;
  logic       r_parity_bit;
  logic       r_start_bit;
  logic       r_stop_bit;
  logic       r_frame_valid;
  logic       r_active;

  logic w_line;
  logic w_fall;
  logic w_vote;
  logic w_tick_last;
  logic w_tick_vote;
  logic w_has_parity;

  rx_sync u_rx_sync (
    .i_clock (clock),
    .i_reset (reset),
    .i_rx    (data_rx),
    .o_line  (w_line),
    .o_fall  (w_fall)
  );

  // The third sample is the live line, so the vote is complete on the C_S2 tick.
  assign w_vote       = maj3(r_s0, r_s1, w_line);
  assign w_tick_last  = baud_tick && (r_cnt == C_LAST);
  assign w_tick_vote  = baud_tick && (r_cnt == C_S2);
  assign w_has_parity = (r_ptype == PAR_ODD) || (r_ptype == PAR_EVEN);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= 4'd0;
      r_bit_idx     <= 3'd0;
      r_ptype       <= 2'b00;
      r_s0          <= 1'b1;
      r_s1          <= 1'b1;
      r_sh_data     <= 8'h00;
      r_sh_parity   <= 1'b0;
      r_sh_start    <= 1'b0;
      r_sh_stop     <= 1'b1;
      r_raw_data    <= 8'h00;
      r_parity_bit  <= 1'b0;
      r_start_bit   <= 1'b0;
      r_stop_bit    <= 1'b1;
      r_frame_valid <= 1'b0;
      r_active      <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;

      // NOTE: this shared counter update is a default; a later assignment
      // to r_cnt in the case below overrides it (last non-blocking write wins).
      if (r_state != S_IDLE && r_state != S_DONE && baud_tick)
        r_cnt <= w_tick_last ? 4'd0 : r_cnt + 4'd1;

      if (baud_tick && r_cnt == C_S0) r_s0 <= w_line;
      if (baud_tick && r_cnt == C_S1) r_s1 <= w_line;

      case (r_state)
        S_IDLE: begin
          r_cnt <= 4'd0;
          if (w_fall) begin
            r_state     <= S_START;
            r_ptype     <= parity_type;
            r_bit_idx   <= 3'd0;
            r_sh_parity <= 1'b0;
            r_active    <= 1'b1;
          end
        end

        S_START: begin
          if (w_tick_vote) begin
            r_sh_start <= w_vote;
            if (w_vote) begin
              // False start: the line was back high by mid-bit.
              r_state  <= S_IDLE;
              r_cnt    <= 4'd0;
              r_active <= 1'b0;
            end
          end else if (w_tick_last) begin
            r_state <= S_DATA;
          end
        end

        S_DATA: begin
          if (w_tick_vote)
            r_sh_data <= {w_vote, r_sh_data[7:1]};
          if (w_tick_last) begin
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7)
              r_state <= w_has_parity ? S_PARITY : S_STOP;
          end
        end

        S_PARITY: begin
          if (w_tick_vote)
            r_sh_parity <= w_vote;
          if (w_tick_last)
            r_state <= S_STOP;
        end

        S_STOP: begin
          // Leave half a bit early so a back-to-back start edge lands in IDLE.
          if (w_tick_vote) begin
            r_sh_stop <= w_vote;
            r_state   <= S_DONE;
            r_cnt     <= 4'd0;
          end
        end

        S_DONE: begin
          r_raw_data    <= r_sh_data;
          r_parity_bit  <= r_sh_parity;
          r_start_bit   <= r_sh_start;
          r_stop_bit    <= r_sh_stop;
          r_frame_valid <= 1'b1;
          r_active      <= 1'b0;
          r_state       <= S_IDLE;
          r_cnt         <= 4'd0;
        end

        default: begin
          r_state  <= S_IDLE;
          r_cnt    <= 4'd0;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign raw_data    = r_raw_data;
  assign parity_bit  = r_parity_bit;
  assign start_bit   = r_start_bit;
  assign stop_bit    = r_stop_bit;
  assign frame_valid = r_frame_valid;
  assign active      = r_active;

endmodule
